// File: rtl/memoria_numeros_pkg.sv
// memoria_numeros_pkg
//   Shared glyph geometry for the seven-segment digit renderer: segment
//   bounding boxes, digit-to-segment table, vertical blanking line and the
//   hit-test helper. Other display blocks (MEMORIA_SP, SINC) import the same
//   constants so every glyph is drawn with identical geometry.
package memoria_numeros_pkg;

  typedef logic [4:0]  row_t;   // glyph row, 0 = top
  typedef logic [3:0]  col_t;   // glyph column, 0 = leftmost
  typedef logic [3:0]  code_t;  // BCD digit code
  typedef logic [9:0]  line_t;  // vertical scan line
  typedef logic [11:0] rgb_t;   // RGB444 pixel colour
  typedef logic [6:0]  segs_t;  // bit 0 = a ... bit 6 = g

  // Inclusive bounding box of one segment inside the 16x32 glyph cell.
  typedef struct packed {
    row_t row_lo;
    row_t row_hi;
    col_t col_lo;
    col_t col_hi;
  } seg_box_t;

  localparam seg_box_t SEG_A = '{row_lo: 5'd1,  row_hi: 5'd3,  col_lo: 4'd3,  col_hi: 4'd12};
  localparam seg_box_t SEG_B = '{row_lo: 5'd3,  row_hi: 5'd15, col_lo: 4'd12, col_hi: 4'd14};
  localparam seg_box_t SEG_C = '{row_lo: 5'd16, row_hi: 5'd28, col_lo: 4'd12, col_hi: 4'd14};
  localparam seg_box_t SEG_D = '{row_lo: 5'd28, row_hi: 5'd30, col_lo: 4'd3,  col_hi: 4'd12};
  localparam seg_box_t SEG_E = '{row_lo: 5'd16, row_hi: 5'd28, col_lo: 4'd1,  col_hi: 4'd3};
  localparam seg_box_t SEG_F = '{row_lo: 5'd3,  row_hi: 5'd15, col_lo: 4'd1,  col_hi: 4'd3};
  localparam seg_box_t SEG_G = '{row_lo: 5'd14, row_hi: 5'd17, col_lo: 4'd3,  col_hi: 4'd12};

  // Active segments per digit, bit order gfedcba.
  localparam segs_t SEGS_0 = 7'b0111111;
  localparam segs_t SEGS_1 = 7'b0000110;
  localparam segs_t SEGS_2 = 7'b1011011;
  localparam segs_t SEGS_3 = 7'b1001111;
  localparam segs_t SEGS_4 = 7'b1100110;
  localparam segs_t SEGS_5 = 7'b1101101;
  localparam segs_t SEGS_6 = 7'b1111101;
  localparam segs_t SEGS_7 = 7'b0000111;
  localparam segs_t SEGS_8 = 7'b1111111;
  localparam segs_t SEGS_9 = 7'b1101111;
  localparam segs_t SEGS_NONE = 7'b0000000;

  // First scan line of vertical blanking.
  localparam line_t BLANK_LINE = 10'd480;

  // True when (row, col) lies inside the box, bounds inclusive.
  function automatic logic in_box(seg_box_t b, row_t row, col_t col);
    return (row >= b.row_lo) && (row <= b.row_hi) &&
           (col >= b.col_lo) && (col <= b.col_hi);
  endfunction

endpackage

// File: rtl/memoria_numeros_if.sv
// memoria_numeros_if
//   Pixel-lookup bundle between a scan-out controller (master) and the digit
//   glyph ROM (slave).
//   direccion      : glyph row 0-31
//   rom            : digit code
//   direccion_data : glyph column 0-15
//   ADDRV          : current vertical scan line
//   NUMEROS        : registered pixel colour returned by the ROM
interface memoria_numeros_if;
  import memoria_numeros_pkg::*;

  row_t  direccion;
  code_t rom;
  col_t  direccion_data;
  line_t ADDRV;
  rgb_t  NUMEROS;

  modport master (output direccion, rom, direccion_data, ADDRV, input NUMEROS);
  modport slave  (input direccion, rom, direccion_data, ADDRV, output NUMEROS);

endinterface

// File: rtl/memoria_numeros_glyph_seg_decode.sv
// glyph_seg_decode
//   Maps a digit code to its seven-segment enable vector (gfedcba).
//   Codes 10-15 enable nothing, so those glyphs render fully unlit.
//   rom  : digit code in
//   segs : segment enables out (combinational)
module glyph_seg_decode
  import memoria_numeros_pkg::*;
(
  input  code_t rom,
  output segs_t segs
);

  // Digit code to segment-enable lookup.
  always_comb begin
    segs = SEGS_NONE;
    case (rom)
      4'd0:    segs = SEGS_0;
      4'd1:    segs = SEGS_1;
      4'd2:    segs = SEGS_2;
      4'd3:    segs = SEGS_3;
      4'd4:    segs = SEGS_4;
      4'd5:    segs = SEGS_5;
      4'd6:    segs = SEGS_6;
      4'd7:    segs = SEGS_7;
      4'd8:    segs = SEGS_8;
      4'd9:    segs = SEGS_9;
      default: segs = SEGS_NONE;
    endcase
  end

endmodule

// File: rtl/memoria_numeros.sv
// memoria_numeros
//   Seven-segment digit glyph ROM (16 cols x 32 rows x 1 bit, 10 digits)
//   followed by one output register. A new pixel can be requested every
//   cycle; the colour appears one CLK later. Lines in vertical blanking
//   always produce black.
//   direccion      : glyph row 0-31
//   rom            : digit code (10-15 render blank)
//   NUMEROS        : registered RGB444 pixel colour
//   direccion_data : glyph column 0-15
//   CLK            : system clock, rising edge
//   RST            : asynchronous active-high reset, forces NUMEROS to black
//   ADDRV          : vertical scan line, used only for the blanking test
module memoria_numeros
  import memoria_numeros_pkg::*;
#(
  parameter rgb_t FG_COLOR = 12'hFFF,
  parameter rgb_t BG_COLOR = 12'h000
) (
  input  row_t  direccion,
  input  code_t rom,
  output rgb_t  NUMEROS,
  input  col_t  direccion_data,
  input  logic  CLK,
  input  logic  RST,
  input  line_t ADDRV
);

  segs_t segs_s;
  segs_t hit_s;
  logic  lit_s;
  rgb_t  pixel_s;
  rgb_t  numeros_r;

  glyph_seg_decode u_seg_decode (
    .rom  (rom),
    .segs (segs_s)
  );

  // Which segment boxes contain the requested pixel, and whether any of
  // them is enabled for this digit.
  always_comb begin
    hit_s = {in_box(SEG_G, direccion, direccion_data),
             in_box(SEG_F, direccion, direccion_data),
             in_box(SEG_E, direccion, direccion_data),
             in_box(SEG_D, direccion, direccion_data),
             in_box(SEG_C, direccion, direccion_data),
             in_box(SEG_B, direccion, direccion_data),
             in_box(SEG_A, direccion, direccion_data)};
    lit_s = |(segs_s & hit_s);
  end

  // Next pixel colour; blanking overrides the glyph and both colours.
  always_comb begin
    pixel_s = 12'h000;
    if (ADDRV >= BLANK_LINE) begin
      pixel_s = 12'h000;
    end else if (lit_s) begin
      pixel_s = FG_COLOR;
    end else begin
      pixel_s = BG_COLOR;
    end
  end

  // Output pixel register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      numeros_r <= 12'h000;
    end else begin
      numeros_r <= pixel_s;
    end
  end

  assign NUMEROS = numeros_r;

endmodule

// File: tb/tb_memoria_numeros.sv
// tb_memoria_numeros
//   Scoreboard bench: each driven pixel pushes its expected colour, which is
//   popped and compared one cycle later. The reference glyph model is written
//   independently from the segment boxes and digit table.
module tb_memoria_numeros;

  logic CLK;
  logic RST;
  memoria_numeros_if bus ();

  memoria_numeros dut (
    .direccion      (bus.direccion),
    .rom            (bus.rom),
    .NUMEROS        (bus.NUMEROS),
    .direccion_data (bus.direccion_data),
    .CLK            (CLK),
    .RST            (RST),
    .ADDRV          (bus.ADDRV)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic ref_lit(int d, int r, int c);
    logic a, b, cc, dd, e, f, g;
    a  = (r >= 1  && r <= 3  && c >= 3  && c <= 12);
    b  = (r >= 3  && r <= 15 && c >= 12 && c <= 14);
    cc = (r >= 16 && r <= 28 && c >= 12 && c <= 14);
    dd = (r >= 28 && r <= 30 && c >= 3  && c <= 12);
    e  = (r >= 16 && r <= 28 && c >= 1  && c <= 3);
    f  = (r >= 3  && r <= 15 && c >= 1  && c <= 3);
    g  = (r >= 14 && r <= 17 && c >= 3  && c <= 12);
    case (d)
      0: return a | b | cc | dd | e | f;
      1: return b | cc;
      2: return a | b | dd | e | g;
      3: return a | b | cc | dd | g;
      4: return b | cc | f | g;
      5: return a | cc | dd | f | g;
      6: return a | cc | dd | e | f | g;
      7: return a | b | cc;
      8: return a | b | cc | dd | e | f | g;
      9: return a | b | cc | dd | f | g;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [11:0] ref_pix(int d, int r, int c, int line);
    if (line >= 480) return 12'h000;
    return ref_lit(d, r, c) ? 12'hFFF : 12'h000;
  endfunction

  // Drive one lookup between edges, then compare one edge later.
  task automatic pixel(input string tag, input int d, input int r, input int c, input int line);
    logic [11:0] exp;
    @(negedge CLK);
    bus.rom            = 4'(d);
    bus.direccion      = 5'(r);
    bus.direccion_data = 4'(c);
    bus.ADDRV          = 10'(line);
    exp_q.push_back(ref_pix(d, r, c, line));
    @(posedge CLK);
    #1;
    exp = exp_q.pop_front();
    check(tag, bus.NUMEROS, exp);
  endtask

  initial begin
    RST = 1'b1;
    bus.rom = 4'd0;
    bus.direccion = 5'd0;
    bus.direccion_data = 4'd0;
    bus.ADDRV = 10'd0;
    #3;
    check("reset_state", bus.NUMEROS, 12'h000);
    @(negedge CLK);
    RST = 1'b0;

    // Directed points
    pixel("d8_seg_a", 8, 2, 5, 100);
    pixel("d1_seg_a_off", 1, 2, 5, 100);
    pixel("d0_mid_g_off", 0, 15, 7, 100);
    pixel("d8_mid_g_on", 8, 15, 7, 100);
    pixel("blank_480", 8, 2, 5, 480);
    pixel("visible_479", 8, 2, 5, 479);
    pixel("blank_500", 8, 2, 5, 500);
    pixel("corner_0_0", 8, 0, 0, 100);
    pixel("corner_31_15", 8, 31, 15, 100);
    pixel("b_edge_14", 1, 3, 14, 100);
    pixel("b_edge_15", 1, 3, 15, 100);

    // Codes 10-15 are fully blank
    for (int k = 10; k <= 15; k++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 16; c++)
          if (k == 10 || (r % 4 == 1 && c % 3 == 0))
            pixel("code_blank", k, r, c, 100);

    // Full sweep of all digits
    for (int d = 0; d < 10; d++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 16; c++)
          pixel("sweep", d, r, c, 100);

    // Asynchronous reset between edges, then recovery
    pixel("pre_reset_lit", 8, 2, 5, 100);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("async_reset", bus.NUMEROS, 12'h000);
    @(negedge CLK);
    check("held_in_reset", bus.NUMEROS, 12'h000);
    RST = 1'b0;
    pixel("after_reset_d7", 7, 2, 5, 100);

    check("scoreboard_empty", 12'(exp_q.size()), 12'h000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
